// File: rtl/mmio_transpose_pkg.sv
// Shared definitions for the mmio_transpose peripheral.
//   - register word offsets relative to BASE
//   - CTRL / STAT bit positions
//   - engine FSM state encoding
//   - index width helper
package mmio_transpose_pkg;

  localparam logic [1:0] OFF_CTRL = 2'd0;
  localparam logic [1:0] OFF_STAT = 2'd1;
  localparam logic [1:0] OFF_IDX  = 2'd2;
  localparam logic [1:0] OFF_DATA = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_IEN   = 1;
  localparam int STAT_BUSY  = 0;
  localparam int STAT_DONE  = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Width of an element pointer into an nn-entry buffer (at least 1 bit).
  function automatic int idx_width(input int nn);
    return (nn > 1) ? $clog2(nn) : 1;
  endfunction

endpackage

// File: rtl/mmio_transpose_if.sv
// MSP430 peripheral bus (per_* signals) as seen by one peripheral.
//   master : CPU side, drives address/data/strobes, samples per_dout
//   slave  : peripheral side, returns per_dout (0 when not addressed)
// Handshake: there is no valid/ready pair. A bus cycle is valid whenever
// per_en is high; the peripheral is always ready. per_we==2'b00 is a read
// whose data is combinational in the same cycle; per_we==2'b11 is a word
// write taking effect at the next mclk edge; other strobes are ignored.
interface mmio_transpose_if;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] per_dout;

  modport master (
    output per_addr, per_din, per_en, per_we,
    input  per_dout
  );

  modport slave (
    input  per_addr, per_din, per_en, per_we,
    output per_dout
  );
endinterface

// File: rtl/mmio_transpose_engine.sv
// transpose_engine: copy sequencer for the transpose peripheral.
// Walks k = 0..N*N-1, one element per clock, and presents
// rd_addr = k (= r*N+c) and wr_addr = c*N+r with r = k/N, c = k%N.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start_i      begin a pass (ignored while running)
//   state_o      current FSM state (debug / busy)
//   copy_we_o    out_buf write enable for this cycle
//   rd_addr_o    in_buf index to copy from
//   wr_addr_o    out_buf index to copy to
//   last_o       high during the cycle that copies the final element
module transpose_engine
  import mmio_transpose_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  output state_e        state_o,
  output logic          copy_we_o,
  output logic [IW-1:0] rd_addr_o,
  output logic [IW-1:0] wr_addr_o,
  output logic          last_o
);

  localparam int NN = N * N;

  state_e        state_q, state_d;
  logic [IW-1:0] k_q, k_d;
  int            k_int, r_int, c_int;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    copy_we_o = 1'b0;
    last_o    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_RUN;
          k_d     = '0;
        end
      end
      ST_RUN: begin
        copy_we_o = 1'b1;
        if (k_q == IW'(NN - 1)) begin
          state_d = ST_IDLE;
          k_d     = '0;
          last_o  = 1'b1;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        k_d     = '0;
      end
    endcase
  end

  always_comb begin
    k_int     = int'(k_q);
    r_int     = k_int / N;
    c_int     = k_int % N;
    rd_addr_o = k_q;
    wr_addr_o = IW'(c_int * N + r_int);
  end

  assign state_o = state_q;

endmodule

// File: rtl/mmio_transpose.sv
// mmio_transpose: memory-mapped NxN matrix transpose peripheral.
// The CPU fills in_buf through IDX/DATA, writes CTRL.START, and reads the
// transposed matrix from out_buf through IDX/DATA once STAT.DONE is set.
// Registers (word offsets from BASE):
//   +0 CTRL  W bit0 START (reads 0), bit1 IEN (R/W, irq build only)
//   +1 STAT  R bit0 BUSY, bit1 DONE; W bit1=1 clears DONE
//   +2 IDX   R/W element pointer, wraps N*N-1 -> 0
//   +3 DATA  W in_buf[IDX]=din, IDX++; R out_buf[IDX], IDX++
// Ports:
//   mclk      system clock
//   puc_rst   asynchronous active-high power-up clear
//   bus       per_* peripheral bus (slave modport)
//   irq       DONE & IEN, registered level (only with TRANSPOSE_IRQ_EN)
// Build option: define TRANSPOSE_IRQ_EN to add the irq port and CTRL.IEN.
module mmio_transpose
  import mmio_transpose_pkg::*;
#(
  parameter int          N    = 4,
  parameter logic [13:0] BASE = 14'h90
) (
  input  logic             mclk,
  input  logic             puc_rst,
  mmio_transpose_if.slave  bus
`ifdef TRANSPOSE_IRQ_EN
  ,
  output logic             irq
`endif
);

  localparam int DW = 16;
  localparam int NN = N * N;
  localparam int IW = idx_width(NN);

  // ---------------- bus decode ----------------
  logic [13:0] off;
  logic [1:0]  reg_sel;
  logic        hit, wr_en, rd_en;
  logic        wr_ctrl, wr_stat, wr_idx, wr_data, rd_data;

  assign off     = bus.per_addr - BASE;
  assign reg_sel = off[1:0];
  assign hit     = bus.per_en && (off < 14'd4);
  assign wr_en   = hit && (bus.per_we == 2'b11);
  assign rd_en   = hit && (bus.per_we == 2'b00);
  assign wr_ctrl = wr_en && (reg_sel == OFF_CTRL);
  assign wr_stat = wr_en && (reg_sel == OFF_STAT);
  assign wr_idx  = wr_en && (reg_sel == OFF_IDX);
  assign wr_data = wr_en && (reg_sel == OFF_DATA);
  assign rd_data = rd_en && (reg_sel == OFF_DATA);

  // ---------------- engine ----------------
  state_e        eng_state;
  logic          eng_we, eng_last, busy, start;
  logic [IW-1:0] eng_rd_addr, eng_wr_addr;

  assign busy  = (eng_state == ST_RUN);
  assign start = wr_ctrl && bus.per_din[CTRL_START] && !busy;

  transpose_engine #(.N(N), .IW(IW)) u_engine (
    .clk       (mclk),
    .rst       (puc_rst),
    .start_i   (start),
    .state_o   (eng_state),
    .copy_we_o (eng_we),
    .rd_addr_o (eng_rd_addr),
    .wr_addr_o (eng_wr_addr),
    .last_o    (eng_last)
  );

  // ---------------- control registers ----------------
  logic [IW-1:0] idx_q, idx_d, idx_next;
  logic          done_q, done_d;
  logic          in_we;
`ifdef TRANSPOSE_IRQ_EN
  logic          ien_q, ien_d;
  logic          irq_q, irq_d;
`endif

  assign idx_next = (idx_q == IW'(NN - 1)) ? '0 : idx_q + 1'b1;

  always_comb begin
    idx_d  = idx_q;
    done_d = done_q;
    in_we  = 1'b0;
    // Buffers and IDX are frozen while the engine owns them.
    if (!busy) begin
      if (wr_idx) begin
        idx_d = bus.per_din[IW-1:0];
      end else if (wr_data) begin
        in_we = 1'b1;
        idx_d = idx_next;
      end else if (rd_data) begin
        idx_d = idx_next;
      end
    end
    if (start) done_d = 1'b0;
    if (wr_stat && bus.per_din[STAT_DONE]) done_d = 1'b0;
    // Completion is applied last so it wins over a simultaneous W1C.
    if (eng_last) done_d = 1'b1;
  end

`ifdef TRANSPOSE_IRQ_EN
  always_comb begin
    ien_d = ien_q;
    if (wr_ctrl) ien_d = bus.per_din[CTRL_IEN];
    irq_d = done_d & ien_d;
  end
`endif

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      idx_q  <= '0;
      done_q <= 1'b0;
`ifdef TRANSPOSE_IRQ_EN
      ien_q  <= 1'b0;
      irq_q  <= 1'b0;
`endif
    end else begin
      idx_q  <= idx_d;
      done_q <= done_d;
`ifdef TRANSPOSE_IRQ_EN
      ien_q  <= ien_d;
      irq_q  <= irq_d;
`endif
    end
  end

`ifdef TRANSPOSE_IRQ_EN
  assign irq = irq_q;
`endif

  // ---------------- element buffers (no reset: contents undefined) ----------------
  logic [DW-1:0] in_buf_q  [NN];
  logic [DW-1:0] out_buf_q [NN];

  always_ff @(posedge mclk) begin
    if (in_we)  in_buf_q[idx_q]        <= bus.per_din;
    if (eng_we) out_buf_q[eng_wr_addr] <= in_buf_q[eng_rd_addr];
  end

  // ---------------- read mux ----------------
  logic [DW-1:0] dout;

  always_comb begin
    dout = '0;
    if (rd_en) begin
      case (reg_sel)
        OFF_CTRL: begin
`ifdef TRANSPOSE_IRQ_EN
          dout[CTRL_IEN] = ien_q;
`else
          dout = '0;
`endif
        end
        OFF_STAT: begin
          dout[STAT_BUSY] = busy;
          dout[STAT_DONE] = done_q;
        end
        OFF_IDX:  dout[IW-1:0] = idx_q;
        OFF_DATA: if (!busy) dout = out_buf_q[idx_q];
        default:  dout = '0;
      endcase
    end
  end

  assign bus.per_dout = dout;

endmodule

// File: tb/tb_mmio_transpose.sv
module tb_mmio_transpose;

  localparam logic [13:0] BASE  = 14'h90;
  localparam logic [13:0] A_CTRL = BASE + 14'd0;
  localparam logic [13:0] A_STAT = BASE + 14'd1;
  localparam logic [13:0] A_IDX  = BASE + 14'd2;
  localparam logic [13:0] A_DATA = BASE + 14'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef TRANSPOSE_IRQ_EN
  logic irq;
`endif

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q[$];
  logic [15:0] model_in [16];

  mmio_transpose_if bus();

  mmio_transpose #(.N(4), .BASE(BASE)) dut (
    .mclk    (clk),
    .puc_rst (rst),
    .bus     (bus)
`ifdef TRANSPOSE_IRQ_EN
    ,
    .irq     (irq)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic bus_idle();
    bus.per_en   = 1'b0;
    bus.per_we   = 2'b00;
    bus.per_addr = '0;
    bus.per_din  = '0;
  endtask

  task automatic bus_write(input logic [13:0] addr, input logic [15:0] data,
                           input logic [1:0] we = 2'b11);
    bus.per_addr = addr;
    bus.per_din  = data;
    bus.per_we   = we;
    bus.per_en   = 1'b1;
    @(posedge clk);
    #1;
    bus_idle();
  endtask

  task automatic bus_read(input logic [13:0] addr, output logic [15:0] data);
    bus.per_addr = addr;
    bus.per_din  = '0;
    bus.per_we   = 2'b00;
    bus.per_en   = 1'b1;
    #1;
    data = bus.per_dout;
    @(posedge clk);
    #1;
    bus_idle();
  endtask

  task automatic load_matrix();
    bus_write(A_IDX, 16'd0);
    for (int i = 0; i < 16; i++) bus_write(A_DATA, model_in[i]);
  endtask

  // out[j] with j = a*4+b holds in[b*4+a].
  task automatic push_expected();
    for (int j = 0; j < 16; j++) exp_q.push_back(model_in[(j % 4) * 4 + (j / 4)]);
  endtask

  // Called right after the START write edge t; read number j samples the
  // state after edge t+j. BUSY until t+16, DONE exactly at t+16.
  task automatic poll_done(input string name, input int j0);
    logic [15:0] d, e;
    for (int j = j0; j <= 16; j++) begin
      bus_read(A_STAT, d);
      e = (j < 16) ? 16'h0001 : 16'h0002;
      tests++;
      if (d !== e) begin
        fails++;
        $display("FAIL %s stat j=%0d: got %h expected %h", name, j, d, e);
      end
    end
  endtask

  // Scoreboard: read out_buf from IDX=0 and pop expected values.
  task automatic drain_compare(input string name);
    logic [15:0] d, e;
    bus_write(A_IDX, 16'd0);
    for (int j = 0; j < 16; j++) begin
      bus_read(A_DATA, d);
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL %s data[%0d]: got %h expected <empty queue>", name, j, d);
      end else begin
        e = exp_q.pop_front();
        if (d !== e) begin
          fails++;
          $display("FAIL %s data[%0d]: got %h expected %h", name, j, d, e);
        end
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [15:0] d;
    bus_idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (bus.per_dout !== 16'h0000) begin
      fails++; $display("FAIL reset dout: got %h expected 0000", bus.per_dout);
    end
    rst = 1'b0;
    bus_read(A_STAT, d);
    tests++;
    if (d !== 16'h0000) begin fails++; $display("FAIL reset stat: got %h expected 0000", d); end
    bus_read(A_IDX, d);
    tests++;
    if (d !== 16'h0000) begin fails++; $display("FAIL reset idx: got %h expected 0000", d); end
    bus_read(A_CTRL, d);
    tests++;
    if (d !== 16'h0000) begin fails++; $display("FAIL reset ctrl: got %h expected 0000", d); end
`ifdef TRANSPOSE_IRQ_EN
    tests++;
    if (irq !== 1'b0) begin fails++; $display("FAIL reset irq: got %b expected 0", irq); end
`endif
  endtask

  task automatic test_load_transpose();
    logic [15:0] d;
    for (int i = 0; i < 16; i++) model_in[i] = 16'(i);
    load_matrix();
    bus_read(A_IDX, d);
    tests++;
    if (d !== 16'h0000) begin fails++; $display("FAIL load idx_wrap: got %h expected 0000", d); end
    push_expected();
    bus_write(A_CTRL, 16'h0001);
    poll_done("load", 0);
    drain_compare("load");
  endtask

  task automatic test_busy_ignore();
    logic [15:0] d;
    push_expected();
    bus_write(A_CTRL, 16'h0001);   // edge t
    bus_write(A_CTRL, 16'h0001);   // t+1: START while busy
    bus_write(A_DATA, 16'hFFFF);   // t+2: DATA write while busy
    bus_write(A_IDX,  16'd5);      // t+3: IDX write while busy
    bus_read(A_DATA, d);           // sampled after t+3
    tests++;
    if (d !== 16'h0000) begin fails++; $display("FAIL busy data_read: got %h expected 0000", d); end
    poll_done("busy", 4);
    bus_read(A_IDX, d);
    tests++;
    if (d !== 16'h0000) begin fails++; $display("FAIL busy idx: got %h expected 0000", d); end
    drain_compare("busy");
  endtask

  task automatic test_idx_wrap();
    logic [15:0] d;
    bus_write(A_IDX, 16'd15);
    bus_write(A_DATA, 16'hAAAA);
    bus_write(A_DATA, 16'h5555);
    model_in[15] = 16'hAAAA;
    model_in[0]  = 16'h5555;
    bus_read(A_IDX, d);
    tests++;
    if (d !== 16'h0001) begin fails++; $display("FAIL wrap idx: got %h expected 0001", d); end
    push_expected();
    bus_write(A_CTRL, 16'h0001);
    poll_done("wrap", 0);
    drain_compare("wrap");
  endtask

  task automatic test_byte_write_unmapped();
    logic [15:0] d;
    bus_write(A_IDX, 16'd3);
    bus_write(A_IDX, 16'd9, 2'b01);
    bus_write(A_IDX, 16'd10, 2'b10);
    bus_read(A_IDX, d);
    tests++;
    if (d !== 16'h0003) begin fails++; $display("FAIL bytewr idx: got %h expected 0003", d); end
    bus_read(BASE + 14'd4, d);
    tests++;
    if (d !== 16'h0000) begin fails++; $display("FAIL unmapped hi: got %h expected 0000", d); end
    bus_read(BASE - 14'd1, d);
    tests++;
    if (d !== 16'h0000) begin fails++; $display("FAIL unmapped lo: got %h expected 0000", d); end
    bus.per_addr = A_STAT; bus.per_en = 1'b0; bus.per_we = 2'b00;
    #1;
    tests++;
    if (bus.per_dout !== 16'h0000) begin
      fails++; $display("FAIL no_en dout: got %h expected 0000", bus.per_dout);
    end
    bus_idle();
  endtask

  task automatic test_w1c_race();
    logic [15:0] d;
    push_expected();
    bus_write(A_CTRL, 16'h0001);           // edge t
    for (int j = 0; j < 15; j++) bus_read(A_STAT, d);  // edges t+1..t+15
    bus_write(A_STAT, 16'h0002);           // W1C on edge t+16, where DONE sets
    bus_read(A_STAT, d);
    tests++;
    if (d !== 16'h0002) begin fails++; $display("FAIL race set_wins: got %h expected 0002", d); end
    bus_write(A_STAT, 16'h0002);
    bus_read(A_STAT, d);
    tests++;
    if (d !== 16'h0000) begin fails++; $display("FAIL race w1c: got %h expected 0000", d); end
    drain_compare("race");
  endtask

  task automatic test_irq();
    logic [15:0] d;
`ifdef TRANSPOSE_IRQ_EN
    bus_write(A_CTRL, 16'h0002);
    bus_read(A_CTRL, d);
    tests++;
    if (d !== 16'h0002) begin fails++; $display("FAIL irq ctrl_ien: got %h expected 0002", d); end
    push_expected();
    bus_write(A_CTRL, 16'h0003);
    tests++;
    if (irq !== 1'b0) begin fails++; $display("FAIL irq early: got %b expected 0", irq); end
    poll_done("irq", 0);
    tests++;
    if (irq !== 1'b1) begin fails++; $display("FAIL irq with_done: got %b expected 1", irq); end
    bus_write(A_STAT, 16'h0002);
    tests++;
    if (irq !== 1'b0) begin fails++; $display("FAIL irq w1c: got %b expected 0", irq); end
    drain_compare("irq");
`else
    bus_write(A_CTRL, 16'h0002);
    bus_read(A_CTRL, d);
    tests++;
    if (d !== 16'h0000) begin fails++; $display("FAIL noirq ctrl: got %h expected 0000", d); end
`endif
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] d;
    for (int i = 0; i < 16; i++) model_in[i] = 16'($urandom_range(0, 16'hFFFF));
    load_matrix();
    bus_write(A_CTRL, 16'h0001);          // edge t
    for (int j = 0; j < 8; j++) bus_read(A_STAT, d);
    rst = 1'b1;
    #1;
    tests++;
    if (bus.per_dout !== 16'h0000) begin
      fails++; $display("FAIL midrst dout: got %h expected 0000", bus.per_dout);
    end
`ifdef TRANSPOSE_IRQ_EN
    tests++;
    if (irq !== 1'b0) begin fails++; $display("FAIL midrst irq: got %b expected 0", irq); end
`endif
    bus_read(A_STAT, d);
    tests++;
    if (d !== 16'h0000) begin fails++; $display("FAIL midrst stat: got %h expected 0000", d); end
    bus_read(A_IDX, d);
    tests++;
    if (d !== 16'h0000) begin fails++; $display("FAIL midrst idx: got %h expected 0000", d); end
    rst = 1'b0;
    for (int i = 0; i < 16; i++) model_in[i] = 16'($urandom_range(0, 16'hFFFF));
    load_matrix();
    push_expected();
    bus_write(A_CTRL, 16'h0001);
    poll_done("postrst", 0);
    drain_compare("postrst");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus_idle();
    test_reset();
    test_load_transpose();
    test_busy_ignore();
    test_idx_wrap();
    test_byte_write_unmapped();
    test_w1c_race();
    test_irq();
    test_reset_mid_run();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
